// File: rtl/sous_huit_serie.sv
// Bit-serial LSB-first subtractor: {bout, d} = a - b - bin, one full-subtractor bit per RUN cycle.
// Latency: start sampled at edge k, done high in the cycle after edge k+WIDTH; one op per WIDTH+2 cycles.
// Backpressure: none; start is only sampled in IDLE, requests during RUN/DONE are dropped.
module sous_huit_serie #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sacc;
    logic             br;
    logic             diff;
    logic             br_nxt;
    logic             last;

    // One full-subtractor slice operating on the LSBs of the shift registers.
    assign diff   = sa[0] ^ sb[0] ^ br;
    assign br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign last   = (cnt == CW'(WIDTH - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            sa   <= '0;
            sb   <= '0;
            sacc <= '0;
            br   <= 1'b0;
            d    <= '0;
            bout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa   <= a;
                        sb   <= b;
                        br   <= bin;
                        cnt  <= '0;
                        sacc <= '0;
                    end
                end
                RUN: begin
                    sa   <= sa >> 1;
                    sb   <= sb >> 1;
                    br   <= br_nxt;
                    sacc <= {diff, sacc[WIDTH-1:1]};
                    // Counter stops at WIDTH-1 so it never wraps inside an operation.
                    if (!last) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        d    <= {diff, sacc[WIDTH-1:1]};
                        bout <= br_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sous_huit_serie.sv
// Randomized and directed bench for sous_huit_serie against an arithmetic reference model.
module tb_sous_huit_serie;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bout;
    logic         busy;
    logic         done;

    int n_chk  = 0;
    int n_fail = 0;

    sous_huit_serie #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .d     (d),
        .bout  (bout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction, folded into W bits plus a borrow flag.
    function automatic longint ref_d(input longint ra, input longint rb, input longint rbin);
        longint diff;
        diff = ra - rb - rbin;
        return diff & ((longint'(1) << W) - 1);
    endfunction

    function automatic longint ref_bout(input longint ra, input longint rb, input longint rbin);
        return (ra < rb + rbin) ? 1 : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issues one operation; optionally re-drives start and operands mid-RUN.
    task automatic run_op(input string tag, input logic [W-1:0] ra, input logic [W-1:0] rb,
                          input logic rbin, input bit perturb);
        longint ed, eb, prev_d;
        int     e, busycnt;
        bit     seen;
        ed      = ref_d(ra, rb, rbin);
        eb      = ref_bout(ra, rb, rbin);
        prev_d  = d;
        a       = ra;
        b       = rb;
        bin     = rbin;
        start   = 1'b1;
        step();
        start   = 1'b0;
        e       = 0;
        busycnt = 0;
        seen    = 1'b0;
        for (int i = 0; i < W + 6; i++) begin
            chk({tag, "_excl"}, longint'(busy & done), 0);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (e == 2) chk({tag, "_dhold"}, d, prev_d);
            busycnt += busy;
            if (perturb && e == 3) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
                bin   = 1'($urandom);
            end
            step();
            e++;
        end
        chk({tag, "_seen"}, seen, 1);
        chk({tag, "_lat"}, e, W);
        chk({tag, "_busy"}, busycnt, W);
        chk({tag, "_d"}, d, ed);
        chk({tag, "_bout"}, bout, eb);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        step();
        chk({tag, "_dpulse"}, done, 0);
        chk({tag, "_dkeep"}, d, ed);
    endtask

    initial begin
        int dcount, last_t, pulses;
        longint ed, eb;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        step();
        step();
        chk("rst_d", d, 0);
        chk("rst_bout", bout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        step();

        run_op("t217_151", 8'd217, 8'd151, 1'b0, 1'b0);
        run_op("t112_151", 8'd112, 8'd151, 1'b0, 1'b0);
        run_op("t238_21", 8'd238, 8'd21, 1'b0, 1'b0);
        run_op("t0_0_1", 8'd0, 8'd0, 1'b1, 1'b0);
        run_op("tmax", 8'd255, 8'd0, 1'b0, 1'b0);
        run_op("tborrow_eq", 8'd10, 8'd9, 1'b1, 1'b0);

        // Mid-RUN start and operand changes must be ignored and produce no extra done.
        run_op("tperturb", 8'd100, 8'd30, 1'b0, 1'b1);
        dcount = 0;
        for (int i = 0; i < 2 * W; i++) begin
            dcount += done;
            step();
        end
        chk("perturb_extra_done", dcount, 0);

        // Reset in cycle 5 of RUN aborts without a done pulse.
        a     = 8'd200;
        b     = 8'd3;
        bin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("rstrun_busy_pre", busy, 1);
        rst_n = 1'b0;
        step();
        chk("rstrun_busy", busy, 0);
        chk("rstrun_d", d, 0);
        chk("rstrun_bout", bout, 0);
        chk("rstrun_done", done, 0);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < W + 2; i++) begin
            dcount += done;
            step();
        end
        chk("rstrun_nodone", dcount, 0);
        run_op("t255_255", 8'd255, 8'd255, 1'b0, 1'b0);

        // Start held high: one operation every W+2 cycles.
        a      = 8'd77;
        b      = 8'd199;
        bin    = 1'b1;
        ed     = ref_d(77, 199, 1);
        eb     = ref_bout(77, 199, 1);
        start  = 1'b1;
        pulses = 0;
        last_t = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) begin
                if (last_t >= 0) chk("held_spacing", i - last_t, W + 2);
                chk("held_d", d, ed);
                chk("held_bout", bout, eb);
                last_t = i;
                pulses++;
            end
        end
        start = 1'b0;
        chk("held_pulses", pulses, 4);
        for (int i = 0; i < 2 * W; i++) step();

        for (int n = 0; n < 30; n++) begin
            run_op($sformatf("rnd%0d", n), W'($urandom), W'($urandom), 1'($urandom),
                   bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
